// File: rtl/follower_pkg.sv
// Shared types and field encodings for the Follower command/control path.
package follower_pkg;

  typedef enum logic [0:0] {IDLE, TRANSIT} state_t;

  localparam logic [1:0] CMD_GO   = 2'b01;
  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] ID_HDR   = 2'b00;

endpackage

// File: rtl/cmd_cntrl_if.sv
// Command/ID handshake and motion-status bundle between the sequencer and its surroundings.
interface cmd_cntrl_if;

  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       clr_cmd_rdy;
  logic [7:0] ID;
  logic       ID_vld;
  logic       clr_ID_vld;
  logic       OK2Move;
  logic       in_transit;
  logic       go;
  logic [5:0] dest_ID;
  logic       arrived;
  logic       buzz;
  logic       buzz_n;

  modport master (
    output cmd, cmd_rdy, ID, ID_vld, OK2Move,
    input  clr_cmd_rdy, clr_ID_vld, in_transit, go, dest_ID, arrived, buzz, buzz_n
  );

  modport slave (
    input  cmd, cmd_rdy, ID, ID_vld, OK2Move,
    output clr_cmd_rdy, clr_ID_vld, in_transit, go, dest_ID, arrived, buzz, buzz_n
  );

endinterface

// File: rtl/cmd_cntrl_buzz_gen.sv
// Obstacle buzzer: square wave toggling every BUZZ_HALF cycles while enabled, silent otherwise.
module buzz_gen #(
  parameter int unsigned BUZZ_HALF = 6250,
  parameter int unsigned BUZZ_W    = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic buzz,
  output logic buzz_n
);

  localparam logic [BUZZ_W-1:0] Wrap = BUZZ_W'(BUZZ_HALF - 1);

  logic [BUZZ_W-1:0] cnt_q, cnt_d;
  logic              buzz_q, buzz_d;
  logic              buzz_n_q;

  always_comb begin
    cnt_d  = '0;
    buzz_d = 1'b0;
    if (en) begin
      if (cnt_q == Wrap) begin
        cnt_d  = '0;
        buzz_d = ~buzz_q;
      end else begin
        cnt_d  = cnt_q + BUZZ_W'(1);
        buzz_d = buzz_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      buzz_q   <= 1'b0;
      buzz_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      buzz_q   <= buzz_d;
      buzz_n_q <= ~buzz_d;
    end
  end

  assign buzz   = buzz_q;
  assign buzz_n = buzz_n_q;

endmodule

// File: rtl/cmd_cntrl.sv
// Follower command sequencer: consumes commands and station IDs, tracks the destination,
// and gates motion and the obstacle buzzer.
import follower_pkg::*;

module cmd_cntrl #(
  parameter int unsigned BUZZ_HALF = 6250,
  parameter int unsigned BUZZ_W    = 13
) (
  input logic         clk,
  input logic         rst,
  cmd_cntrl_if.slave  bus
);

  state_t     state_q, state_d;
  logic [5:0] dest_q, dest_d;
  logic       arrived_q, arrived_d;
  logic       clr_cmd_q, clr_id_q;
  logic       cmd_take, id_take;
  logic       in_transit;

  // A level still high during its own acknowledge cycle is the same item, not a new one.
  assign cmd_take   = bus.cmd_rdy & ~clr_cmd_q;
  assign id_take    = bus.ID_vld & ~clr_id_q;
  assign in_transit = (state_q == TRANSIT);

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    arrived_d = 1'b0;
    if (cmd_take) begin
      // A simultaneous ID is acknowledged but never compared.
      case (bus.cmd[7:6])
        CMD_GO: begin
          dest_d  = bus.cmd[5:0];
          state_d = TRANSIT;
        end
        CMD_STOP: state_d = IDLE;
        default:  ;
      endcase
    end else if (id_take && in_transit && bus.ID[7:6] == ID_HDR && bus.ID[5:0] == dest_q) begin
      state_d   = IDLE;
      arrived_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dest_q    <= '0;
      arrived_q <= 1'b0;
      clr_cmd_q <= 1'b0;
      clr_id_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      arrived_q <= arrived_d;
      clr_cmd_q <= cmd_take;
      clr_id_q  <= id_take;
    end
  end

  buzz_gen #(
    .BUZZ_HALF (BUZZ_HALF),
    .BUZZ_W    (BUZZ_W)
  ) u_buzz_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (in_transit & ~bus.OK2Move),
    .buzz   (bus.buzz),
    .buzz_n (bus.buzz_n)
  );

  assign bus.clr_cmd_rdy = clr_cmd_q;
  assign bus.clr_ID_vld  = clr_id_q;
  assign bus.in_transit  = in_transit;
  assign bus.go          = in_transit & bus.OK2Move;
  assign bus.dest_ID     = dest_q;
  assign bus.arrived     = arrived_q;

endmodule
